// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin N-to-1 FIFO write arbiter with pulse+gap write timing.
// Optional per-requester accept and stall counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic [IDW-1:0]     grant_id,
  output logic               w_valid,
  output logic [WIDTH-1:0]   data_in,
  input  logic               fifo_full,
  output logic [N*16-1:0]    accept_cnt,
  output logic [15:0]        stall_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [N-1:0]     ready_q, ready_d;
  logic             w_valid_q, w_valid_d;
  logic [IDW-1:0]   winner;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             decide;
  logic             grant;

  // Two passes: indices at/after rr_ptr first, then the wrapped-around ones.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && i >= int'(rr_ptr_q) && req_valid[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == winner) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // fifo_full is only trusted outside WRITE; the gap lets its registered update land.
  assign decide = (state_q != S_WRITE);
  assign grant  = decide && found && !fifo_full;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    w_valid_d  = grant;
    for (int i = 0; i < N; i++) ready_d[i] = grant && (IDW'(i) == winner);
    case (state_q)
      S_WRITE: state_d = S_GAP;
      default: state_d = grant ? S_WRITE : S_IDLE;
    endcase
    if (grant) begin
      data_d     = win_data;
      grant_id_d = winner;
      rr_ptr_d   = (int'(winner) == N - 1) ? '0 : winner + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      data_q     <= '0;
      ready_q    <= '0;
      w_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      w_valid_q  <= w_valid_d;
    end
  end

  assign req_ready = ready_q;
  assign grant_id  = grant_id_q;
  assign w_valid   = w_valid_q;
  assign data_in   = data_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N-1:0][15:0] acc_q;
  logic [15:0]        stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == S_WRITE) begin
        for (int i = 0; i < N; i++) begin
          if (IDW'(i) == grant_id_q && acc_q[i] != 16'hFFFF) acc_q[i] <= acc_q[i] + 16'd1;
        end
      end
      if (decide && found && fifo_full && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign accept_cnt = acc_q;
  assign stall_cnt  = stall_q;
`else
  assign accept_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter with a small FIFO model.
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [1:0]   grant_id;
  logic         w_valid;
  logic [31:0]  data_in;
  logic         fifo_full;
  logic [63:0]  accept_cnt;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(4), .WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .w_valid   (w_valid),
    .data_in   (data_in),
    .fifo_full (fifo_full),
    .accept_cnt(accept_cnt),
    .stall_cnt (stall_cnt)
  );

  // FIFO model with registered full flag
  int          fifo_depth = 16;
  logic        r_ready = 1'b0;
  logic [31:0] fq[$];
  logic [31:0] popped[$];
  int          overflow = 0;
  logic        full_q = 1'b0;

  assign fifo_full = full_q;

  always @(posedge clk) begin
    if (reset) begin
      fq.delete();
      full_q <= 1'b0;
    end else begin
      if (r_ready && fq.size() > 0) popped.push_back(fq.pop_front());
      if (w_valid) begin
        if (fq.size() >= fifo_depth) overflow <= overflow + 1;
        else fq.push_back(data_in);
      end
      full_q <= (fq.size() >= fifo_depth);
    end
  end

  logic        auto_data = 1'b0;
  logic [3:0]  last_ready = '0;
  logic [31:0] next_val;
  int          wcount = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_data) begin
      for (int i = 0; i < 4; i++) begin
        if (last_ready[i]) begin
          req_data[i*32 +: 32] = next_val;
          next_val = next_val + 1;
        end
      end
    end
    last_ready = req_ready;
    if (w_valid) wcount++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);

    // Reset held two cycles with all requesters valid
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_w_valid", 64'(w_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_data_in", 64'(data_in), 64'd0);
    end
    reset = 1'b0;
    tick();
    chk("first_grant_w_valid", 64'(w_valid), 64'd1);
    chk("first_grant_ready", 64'(req_ready), 64'h1);
    chk("first_grant_id", 64'(grant_id), 64'd0);

    // Single requester 2
    req_valid = 4'h0;
    do_reset();
    req_valid = 4'b0100;
    req_data[2*32 +: 32] = 32'hA5A5_0002;
    tick();
    chk("single_w_valid", 64'(w_valid), 64'd1);
    chk("single_data", 64'(data_in), 64'hA5A5_0002);
    chk("single_ready", 64'(req_ready), 64'b0100);
    chk("single_grant_id", 64'(grant_id), 64'd2);
    tick();
    req_valid = 4'h0;
    chk("single_gap_w_valid", 64'(w_valid), 64'd0);
    chk("single_gap_ready", 64'(req_ready), 64'd0);
    chk("single_gap_grant_id", 64'(grant_id), 64'd2);
    tick();
    chk("single_idle_w_valid", 64'(w_valid), 64'd0);
    tick();
    chk("single_idle2_w_valid", 64'(w_valid), 64'd0);

    // All four continuously valid, FIFO drained every cycle
    r_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    do_reset();
    popped.delete();
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("rr_w_valid", 64'(w_valid), 64'd1);
      chk("rr_grant_id", 64'(grant_id), 64'(g % 4));
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (g % 4)));
      chk("rr_data", 64'(data_in), 64'(32'hA5A5_0000 + 32'(g % 4)));
      tick();
      chk("rr_gap_w_valid", 64'(w_valid), 64'd0);
    end
    req_valid = 4'h0;
    tick();
    tick();
    chk("rr_pop_count", 64'(popped.size()), 64'd6);
    for (int g = 0; g < 6 && g < popped.size(); g++)
      chk("rr_pop_order", 64'(popped[g]), 64'(32'hA5A5_0000 + 32'(g % 4)));

    // Depth-3 FIFO, no reads: fill then stall, then one pop allows one more write
    r_ready = 1'b0;
    fifo_depth = 3;
    req_valid = 4'b0011;
    req_data[0 +: 32] = 32'h100;
    req_data[32 +: 32] = 32'h101;
    next_val = 32'h102;
    do_reset();
    popped.delete();
    auto_data = 1'b1;
    last_ready = '0;
    wcount = 0;
    for (int c = 0; c < 10; c++) tick();
    chk("fill_writes", 64'(wcount), 64'd3);
    chk("fill_full", 64'(fifo_full), 64'd1);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    wcount = 0;
    tick();
    tick();
    chk("pop_one_write", 64'(wcount), 64'd1);
    wcount = 0;
    for (int c = 0; c < 4; c++) tick();
    chk("refill_stall", 64'(wcount), 64'd0);
    chk("no_overflow", 64'(overflow), 64'd0);
    chk("fill_popped", 64'(popped.size()), 64'd1);
    if (popped.size() > 0) chk("fill_popped0", 64'(popped[0]), 64'h100);
    chk("fill_fq_size", 64'(fq.size()), 64'd3);
    for (int k = 0; k < 3 && k < fq.size(); k++)
      chk("fill_fq_order", 64'(fq[k]), 64'(32'h101 + 32'(k)));
    auto_data = 1'b0;

    // Reset during a WRITE granted to requester 1
    fifo_depth = 16;
    r_ready = 1'b1;
    req_valid = 4'b0010;
    do_reset();
    tick();
    chk("mid_write_id", 64'(grant_id), 64'd1);
    chk("mid_write_w_valid", 64'(w_valid), 64'd1);
    reset = 1'b1;
    req_valid = 4'b1001;
    tick();
    chk("mid_rst_w_valid", 64'(w_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
    chk("mid_rst_data", 64'(data_in), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_grant_id", 64'(grant_id), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'b0001);
    chk("post_rst_fifo_empty", 64'(fq.size()), 64'd0);
    req_valid = 4'h0;
    tick();

    // Five beats from requester 3 into a depth-5 FIFO, then ten stalled decisions
    r_ready = 1'b0;
    fifo_depth = 5;
    req_valid = 4'b1000;
    do_reset();
    wcount = 0;
    for (int c = 0; c < 20; c++) tick();
    req_valid = 4'h0;
    chk("stats_writes", 64'(wcount), 64'd5);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stats_acc3", 64'(accept_cnt[63:48]), 64'd5);
    chk("stats_acc_others", 64'(accept_cnt[47:0]), 64'd0);
    chk("stats_stall", 64'(stall_cnt), 64'd10);
`else
    chk("stats_acc_off", 64'(accept_cnt), 64'd0);
    chk("stats_stall_off", 64'(stall_cnt), 64'd0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
